load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 70 +++++++
 rtl/lsu_align.sv | 27 ++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - state_t      : FSM state encoding
//   - SZ_*         : access size encodings on the 'size' port
//   - is_misaligned: alignment rule for a size/offset pair
//   - lane_merge   : inserts sub-word store data into a read word
//   - lane_extract : selects and extends the addressed lane of a read word
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size 3 is illegal and always reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic res;
    case (size)
      SZ_BYTE: res = 1'b0;
      SZ_HALF: res = off[0];
      SZ_WORD: res = (off != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane; all other bytes of 'word' pass through.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{off, 3'b000} +: 8]      = wdata[7:0];
      SZ_HALF: res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Right-align the addressed lane, then zero- or sign-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: res = {{24{sext & b[7]}}, b};
      SZ_HALF: res = {{16{sext & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane datapath for the load/store unit.
//   rd_word   in  : word returned by memory
//   wdata     in  : right-aligned store data
//   size      in  : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   offset    in  : byte offset within the word (addr[1:0])
//   sign_ext  in  : sign-extend sub-word loads
//   merged    out : rd_word with the addressed lane replaced by store data
//   extracted out : addressed lane, right-aligned and extended
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  assign merged    = lane_merge(rd_word, wdata, size, offset);
  assign extracted = lane_extract(rd_word, size, offset, sign_ext);

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding-request load/store unit in front of a word-wide memory
// without byte enables. Sub-word stores are done as read-modify-write.
//
// Parameters
//   TIMEOUT_CYC : max cycles to wait for mem_ready on one memory access
//   AW          : byte-address width
// Ports
//   clk, rst_n              : clock (rising edge), async active-low reset
//   start                   : request strobe, only looked at in IDLE
//   is_store, size,
//   sign_ext, addr, wdata   : request attributes, registered on acceptance
//   busy                    : request in flight (RD/WR)
//   done / err              : one-cycle completion / error pulse
//   rdata                   : last load result, held between loads
//   mem_addr                : word index of the access
//   mem_read / mem_write    : memory strobes, never both high
//   mem_wdata               : full word written to memory
//   mem_rdata, mem_ready    : memory return data and handshake
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_store,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [31:0]   mem_addr,
  output logic          mem_write,
  output logic          mem_read,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic          store_q;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;
  logic [31:0]   merged;
  logic [31:0]   extracted;

  // The access times out on the cycle that would be the TIMEOUT_CYC-th
  // without mem_ready, so exactly TIMEOUT_CYC strobe cycles are issued.
  assign timed_out = (wait_cnt == CW'(TIMEOUT_CYC - 1));

  // Strobes and status decode straight from the state register, so an
  // asynchronous reset drops them in the same instant.
  assign busy      = (state == ST_RD) || (state == ST_WR);
  assign mem_read  = (state == ST_RD);
  assign mem_write = (state == ST_WR);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_ERR);
  assign mem_addr  = 32'(addr_q >> 2);

  lsu_align u_align (
    .rd_word   (mem_rdata),
    .wdata     (wdata_q),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sign_ext  (sext_q),
    .merged    (merged),
    .extracted (extracted)
  );

  // NOTE: every register here, datapath included, is reset because the
  // outputs derived from them (mem_addr, mem_wdata, rdata) must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= SZ_BYTE;
      sext_q    <= 1'b0;
      store_q   <= 1'b0;
      wait_cnt  <= '0;
      rdata     <= '0;
      mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state and the registered request.
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            size_q   <= size;
            sext_q   <= sign_ext;
            store_q  <= is_store;
            wait_cnt <= '0;
            if (is_misaligned(size, addr[1:0])) begin
              state <= ST_ERR;
            end else if (is_store && (size == SZ_WORD)) begin
              // Full-word store needs no read; the word is known already.
              state     <= ST_WR;
              mem_wdata <= wdata;
            end else begin
              state <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (mem_ready) begin
            if (store_q) begin
              state     <= ST_WR;
              mem_wdata <= merged;
              wait_cnt  <= '0;
            end else begin
              state <= ST_DONE;
              rdata <= extracted;
            end
          end else if (timed_out) begin
            state <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_WR: begin
          if (mem_ready) begin
            state <= ST_DONE;
          end else if (timed_out) begin
            state <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_DONE, ST_ERR: state <= ST_IDLE;

        // NOTE: an explicit default keeps unused encodings recoverable.
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: a 16-word memory responder with configurable ready
// behaviour, a transaction-level reference model (ref_mem plus expected
// completion queue), a per-cycle compare process, directed cases with literal
// expectations, randomized requests and a mid-access reset.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b1;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(TO), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // ---------------------------------------------------------------- memory
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_write && mem_ready) mem[mem_addr[3:0]] <= mem_wdata;
  end

  // ready_mode: 0 = always ready, 1 = random with bounded stalls, 2 = never
  int ready_mode = 0;
  int stall_run = 0;
  always @(negedge clk) begin
    case (ready_mode)
      0:       mem_ready = 1'b1;
      2:       mem_ready = 1'b0;
      default: mem_ready = (stall_run >= 5) || ($urandom_range(0, 2) != 0);
    endcase
    stall_run = mem_ready ? 0 : stall_run + 1;
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    bit          is_err;
    bit          is_load;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rdata = '0;

  always @(negedge clk) begin : cmp
    exp_t e;
    if (!rst_n) begin
      model_rdata = '0;
      exp_q.delete();
    end else begin
      check("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (done || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", {30'd0, done, err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_pulse", 32'(err), 32'(e.is_err));
          check("done_pulse", 32'(done), 32'(!e.is_err));
          check("busy_at_end", 32'(busy), 32'd0);
          if (done && e.is_load) model_rdata = e.rdata;
        end
      end
      check("rdata", rdata, model_rdata);
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic preload(input logic [3:0] idx, input logic [31:0] v);
    pre_idx = idx;
    pre_val = v;
    pre_we  = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
    ref_mem[idx] = v;
  endtask

  task automatic run_req(input bit st, input logic [1:0] sz, input bit sx,
                         input logic [5:0] a, input logic [31:0] wd,
                         input int mode, output int lat);
    logic [3:0]  idx;
    int          sh;
    bit          mis;
    bit          tmo;
    bit          fin;
    int          n_strb;
    int          first_strb;
    logic [31:0] w;
    logic [31:0] v;
    exp_t        e;
    idx = a[5:2];
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    tmo = !mis && (mode == 2);
    e.is_err  = mis || tmo;
    e.is_load = !st;
    e.rdata   = '0;
    if (!e.is_err) begin
      w = ref_mem[idx];
      if (!st) begin
        case (sz)
          2'd0: begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
          end
          2'd1: begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
          end
          default: v = w;
        endcase
        e.rdata = v;
      end else begin
        case (sz)
          2'd0: begin
            sh = 8 * int'(a[1:0]);
            ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
          end
          2'd1: begin
            sh = 16 * int'(a[1]);
            ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
          end
          default: ref_mem[idx] = wd;
        endcase
      end
    end

    @(negedge clk);
    ready_mode = mode;
    exp_q.push_back(e);
    start    = 1'b1;
    is_store = st;
    size     = sz;
    sign_ext = sx;
    addr     = {26'd0, a};
    wdata    = wd;

    lat = 0;
    fin = 1'b0;
    n_strb = 0;
    first_strb = 0;
    while (!fin && lat < 100) begin
      @(negedge clk);
      lat++;
      if (mem_read || mem_write) begin
        n_strb++;
        if (first_strb == 0) begin
          first_strb = mem_read ? 1 : 2;
          check("mem_addr", mem_addr, {28'd0, a[5:2]});
        end
      end
      if (done || err) begin
        fin = 1'b1;
        start = 1'b0;
      end else begin
        // Garbage while busy; the unit must ignore all of it.
        start    = 1'($urandom_range(0, 1));
        is_store = 1'($urandom_range(0, 1));
        size     = 2'($urandom_range(0, 3));
        sign_ext = 1'($urandom_range(0, 1));
        addr     = $urandom;
        wdata    = $urandom;
      end
    end

    if (!fin) begin
      check("completion_bound", 32'd0, 32'd1);
      start = 1'b0;
      exp_q.delete();
    end else begin
      if (mis) check("misaligned_no_strobe", 32'(n_strb), 32'd0);
      else     check("first_strobe", 32'(first_strb), (!st || sz != 2'd2) ? 32'd1 : 32'd2);
      if (tmo) check("timeout_strobe_cycles", 32'(n_strb), 32'(TO));
      if (mis) check("err_latency", 32'(lat), 32'd1);
      else if (mode == 0) check("latency", 32'(lat), (st && sz != 2'd2) ? 32'd3 : 32'd2);
      check("mem_word", mem[idx], ref_mem[idx]);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int lat;
    int m;
    start = 1'b0;
    is_store = 1'b0;
    size = 2'd0;
    sign_ext = 1'b0;
    addr = '0;
    wdata = '0;

    for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Word and byte loads of 0x8000_00F0
    preload(4'd2, 32'h8000_00F0);
    run_req(1'b0, 2'd2, 1'b0, 6'h08, 32'd0, 0, lat);
    check("lit_word_load", rdata, 32'h8000_00F0);
    check("lit_word_load_lat", 32'(lat), 32'd2);
    run_req(1'b0, 2'd0, 1'b1, 6'h08, 32'd0, 0, lat);
    check("lit_byte_sext", rdata, 32'hFFFF_FFF0);
    run_req(1'b0, 2'd0, 1'b0, 6'h08, 32'd0, 0, lat);
    check("lit_byte_zext", rdata, 32'h0000_00F0);

    // Half store read-modify-write
    preload(4'd2, 32'h1122_3344);
    run_req(1'b1, 2'd1, 1'b0, 6'h0A, 32'h0000_BEEF, 0, lat);
    check("lit_half_rmw_mem", mem[2], 32'hBEEF_3344);
    check("lit_half_rmw_wdata", mem_wdata, 32'hBEEF_3344);
    check("lit_half_rmw_lat", 32'(lat), 32'd3);
    check("rdata_held_over_store", rdata, 32'h0000_00F0);

    // Misaligned word access
    run_req(1'b0, 2'd2, 1'b0, 6'h06, 32'd0, 0, lat);
    check("lit_misaligned_lat", 32'(lat), 32'd1);

    // Timeout on a load, then back to IDLE with strobes low
    run_req(1'b0, 2'd2, 1'b0, 6'h00, 32'd0, 2, lat);
    check("lit_timeout_lat", 32'(lat), 32'(TO + 1));
    @(negedge clk);
    check("timeout_idle_read", 32'(mem_read), 32'd0);
    check("timeout_idle_busy", 32'(busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      m = $urandom_range(0, 9);
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
              $urandom, (m < 5) ? 0 : ((m < 9) ? 1 : 2), lat);
    end

    // Reset during the read phase of a byte store
    preload(4'd5, 32'hA5A5_5A5A);
    @(negedge clk);
    ready_mode = 0;
    start    = 1'b1;
    is_store = 1'b1;
    size     = 2'd0;
    sign_ext = 1'b0;
    addr     = 32'h15;
    wdata    = 32'h77;
    @(posedge clk);
    #2 start = 1'b0;
    check("rmw_in_read", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    check("midrst_done_err", {30'd0, done, err}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_quiet", {29'd0, done, err, mem_write}, 32'd0);
    end
    check("postrst_mem_untouched", mem[5], 32'hA5A5_5A5A);

    // Recovery after reset
    run_req(1'b0, 2'd2, 1'b0, 6'h14, 32'd0, 0, lat);
    check("postrst_load", rdata, 32'hA5A5_5A5A);
    for (int i = 0; i < 10; i++)
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
              $urandom, 1, lat);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
